// File: rtl/mantissa_sqrt_iter.sv
// Iterative restoring square-root engine for the mantissa sqrt datapath.
// Takes a 2*ROOT_W-bit radicand and retires one root bit per clock,
// producing floor(sqrt(radicand)), the remainder and an exactness flag
// ROOT_W cycles after the accepting edge.
module mantissa_sqrt_iter #(
    parameter int ROOT_W = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*ROOT_W-1:0]   radicand,
    output logic                  busy,
    output logic                  done,
    output logic [ROOT_W-1:0]     root,
    output logic [ROOT_W:0]       rem,
    output logic                  exact
);

    localparam int RAD_W = 2 * ROOT_W;
    localparam int P_W   = ROOT_W + 2;
    localparam int CNT_W = (ROOT_W > 1) ? $clog2(ROOT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(ROOT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t             state_reg;
    state_t             state_next;

    logic [RAD_W-1:0]   rad_reg;
    logic [RAD_W-1:0]   rad_next;
    logic [P_W-1:0]     p_reg;
    logic [ROOT_W-1:0]  r_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic               accept;
    logic               running;
    logic               last_iter;

    logic [P_W-1:0]     p_shift;
    logic [P_W-1:0]     trial;
    logic [P_W-1:0]     diff;
    logic               fits;
    logic [P_W-1:0]     p_iter;
    logic [ROOT_W-1:0]  r_iter;

    // A new operation is taken whenever the engine is not iterating.
    assign running   = (state_reg == S_RUN);
    assign accept    = !running && start;
    assign last_iter = running && (cnt_reg == LAST_ITER);

    // State register; reset always returns to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE/DONE accept start, RUN ends after the last bit.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  state_next = start ? S_RUN : S_IDLE;
            S_RUN:   state_next = last_iter ? S_DONE : S_RUN;
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state; busy and done are mutually exclusive.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            S_RUN:   busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Radicand pair shift register: each 2-bit pair either loads from the
    // operand, takes the pair below it while running, or holds.
    generate
        for (genvar gi = 0; gi < ROOT_W; gi++) begin : g_rad_pair
            logic [1:0] pair_shifted;
            if (gi == 0) begin : g_bottom
                assign pair_shifted = 2'b00;
            end else begin : g_upper
                assign pair_shifted = rad_reg[2*gi-1 -: 2];
            end
            assign rad_next[2*gi +: 2] = accept  ? radicand[2*gi +: 2] :
                                         running ? pair_shifted :
                                                   rad_reg[2*gi +: 2];
        end
    endgenerate

    // One restoring step: bring down the next pair, trial-subtract 4R+1.
    // The partial remainder never exceeds 2R, so its top bits drop out of
    // the shift without loss.
    always_comb begin
        p_shift = P_W'({p_reg, rad_reg[RAD_W-1 -: 2]});
        trial   = {r_reg, 2'b01};
        diff    = p_shift - trial;
        fits    = (p_shift >= trial);
        p_iter  = fits ? diff : p_shift;
        r_iter  = {r_reg[ROOT_W-2:0], fits};
    end

    // Iteration datapath: clear on accept, advance one bit per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rad_reg <= '0;
            p_reg   <= '0;
            r_reg   <= '0;
            cnt_reg <= '0;
        end else begin
            rad_reg <= rad_next;
            if (accept) begin
                p_reg   <= '0;
                r_reg   <= '0;
                cnt_reg <= '0;
            end else if (running) begin
                p_reg   <= p_iter;
                r_reg   <= r_iter;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Result registers: capture the final step's values, hold until the next result.
    always_ff @(posedge clk) begin
        if (rst) begin
            root  <= '0;
            rem   <= '0;
            exact <= 1'b0;
        end else if (last_iter) begin
            root  <= r_iter;
            rem   <= p_iter[ROOT_W:0];
            exact <= (p_iter == '0);
        end
    end

endmodule

// File: tb/tb_mantissa_sqrt_iter.sv
// Self-checking bench for mantissa_sqrt_iter: a transaction-level model
// (integer square root by search, busy countdown) is compared against the
// DUT every cycle, with literal expectations for the directed cases.
module tb_mantissa_sqrt_iter;

    localparam int ROOT_W = 11;
    localparam int RAD_W  = 2 * ROOT_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [RAD_W-1:0]  radicand = '0;
    logic              busy;
    logic              done;
    logic [ROOT_W-1:0] root;
    logic [ROOT_W:0]   rem;
    logic              exact;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    mantissa_sqrt_iter #(.ROOT_W(ROOT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .radicand (radicand),
        .busy     (busy),
        .done     (done),
        .root     (root),
        .rem      (rem),
        .exact    (exact)
    );

    always #5 clk = ~clk;

    // Reference arithmetic: integer square root by upward search.
    function automatic logic [ROOT_W-1:0] f_root(input logic [RAD_W-1:0] x);
        longint r;
        r = 0;
        while ((r + 1) * (r + 1) <= longint'(x)) r++;
        return r[ROOT_W-1:0];
    endfunction

    function automatic logic [ROOT_W:0] f_rem(input logic [RAD_W-1:0] x);
        longint r;
        longint d;
        r = longint'(f_root(x));
        d = longint'(x) - r * r;
        return d[ROOT_W:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction model: accept when idle, report result ROOT_W edges later.
    logic              m_busy = 1'b0;
    logic              m_done = 1'b0;
    logic [ROOT_W-1:0] m_root = '0;
    logic [ROOT_W:0]   m_rem = '0;
    logic              m_exact = 1'b0;
    logic [RAD_W-1:0]  m_pend = '0;
    int                m_left = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_root  <= '0;
            m_rem   <= '0;
            m_exact <= 1'b0;
            m_left  <= 0;
        end else if (!m_busy && start) begin
            m_pend <= radicand;
            m_left <= ROOT_W;
            m_busy <= 1'b1;
            m_done <= 1'b0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_root  <= f_root(m_pend);
                m_rem   <= f_rem(m_pend);
                m_exact <= (f_rem(m_pend) == '0);
                $display("txn radicand=%0d root=%0d rem=%0d", m_pend, f_root(m_pend), f_rem(m_pend));
            end
        end else begin
            m_done <= 1'b0;
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("root", root, m_root);
            chk("rem", rem, m_rem);
            chk("exact", exact, m_exact);
            chk("busy_and_done", busy & done, 1'b0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start one operation now, optionally pulse ignored starts while busy,
    // and check latency and result against literal expectations.
    task automatic run_op(input logic [RAD_W-1:0] x, input int exp_root,
                          input int exp_rem, input bit exp_exact, input bit noise);
        int cyc;
        start    = 1'b1;
        radicand = x;
        tick();
        start = 1'b0;
        cyc   = 0;
        while (!done && cyc < 40) begin
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                radicand = 22'd99;
            end else begin
                radicand = RAD_W'($urandom);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        chk("latency", cyc, ROOT_W);
        chk("lit_root", root, exp_root);
        chk("lit_rem", rem, exp_rem);
        chk("lit_exact", exact, exp_exact);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_root", root, 0);
        chk("rst_rem", rem, 0);
        chk("rst_exact", exact, 1'b0);
        rst    = 1'b0;
        chk_en = 1'b1;
        tick();

        run_op(22'd0,        0,    0,    1'b1, 1'b0);
        tick();
        run_op(22'h3FFFFF,   2047, 4094, 1'b0, 1'b0);
        tick();
        run_op(22'h100000,   1024, 0,    1'b1, 1'b0);
        run_op(22'h200000,   1448, 448,  1'b0, 1'b0);
        tick();
        run_op(22'd144,      12,   0,    1'b1, 1'b1);
        run_op(22'd2,        1,    1,    1'b0, 1'b0);

        // Abort mid-run with start held high; the first free edge re-accepts.
        start    = 1'b1;
        radicand = 22'd5000;
        tick();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_root", root, 0);
        chk("abort_rem", rem, 0);
        chk("abort_exact", exact, 1'b0);
        rst = 1'b0;
        run_op(22'd5000,     70,   100,  1'b0, 1'b0);

        // Random traffic: sporadic starts, changing operands, rare resets.
        for (int i = 0; i < 800; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            radicand = RAD_W'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst   = 1'b0;
        start = 1'b0;
        repeat (ROOT_W + 3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mantissa_sqrt_iter.md
# mantissa_sqrt_iter

Iterative restoring (digit-by-digit) square-root engine for the sqrt datapath. It sits directly downstream of the operand alignment stage, where the 11-bit barrel shifters normalise the mantissa into a 2·ROOT_W-bit radicand. It produces one root bit per clock and hands the root, the remainder and an exactness flag to the rounding/packing stage. It is built structurally from the existing primitive library: register_n, register_with_enable, dff, mux2_n, subtractor_n, comparator_gte_n, increment_n, comparator_eq_n and is_zero_n.

## Interface
- ROOT_W, default 11: root width; radicand is 2·ROOT_W bits, remainder is ROOT_W+1 bits.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- radicand  in  2·ROOT_W  unsigned operand; sampled on the accepting edge only.
- busy  out  1  high while iterating.
- done  out  1  one-cycle pulse: results valid.
- root  out  ROOT_W  floor(sqrt(radicand)).
- rem  out  ROOT_W+1  radicand − root².
- exact  out  1  rem == 0.

## Operation
- States: IDLE, RUN, DONE. A dff pair encodes the state.
- IDLE/DONE with start=1 (accepting edge):
  - load radicand into the pair shift register;
  - clear partial root R and partial remainder P;
  - clear the iteration counter; go to RUN.
- DONE with start=0 → IDLE.
- RUN, each edge, in the 13-bit (ROOT_W+2) datapath:
  - P' = (P<<2) | top two radicand bits;
  - T = (R<<2) | 1;
  - if P' ≥ T: P ← P' − T, R ← (R<<1)|1;
  - else: P ← P', R ← R<<1;
  - shift radicand left by 2; increment the counter.
- On the iteration edge where the counter reaches ROOT_W−1 → DONE. On that same edge, load root←R, rem←P[ROOT_W:0] and exact←(P==0).
- Width rules:
  - P' never exceeds 8·(2^(ROOT_W−1)−1)+3, so it fits in ROOT_W+2 bits without overflow.
  - The final remainder is ≤ 2·root, so it fits in ROOT_W+1 bits.
  - Carries out of the top bit are discarded.
- root, rem and exact are output registers. They hold their value from the DONE edge until the next DONE or reset. They do not change during RUN.
- start while busy=1 is ignored, with no queueing. Changes to radicand after the accepting edge have no effect.
- Reset value of every output is 0: busy, done, root, rem, exact. Reset also forces the state to IDLE.
- rst has priority over start on the same edge.
- rst mid-RUN aborts the operation: busy=0 after that edge, no done pulse, outputs cleared.

## Timing
- The accepting edge is E0. Iterations occur on E1..E_ROOT_W.
- busy is high from after E0 until after E_ROOT_W, i.e. ROOT_W cycles. For ROOT_W=11, busy is high for 11 cycles.
- done is high for exactly one cycle, after E_ROOT_W. Outputs are valid in that cycle.
- Latency from the accepting edge to done rising is ROOT_W cycles.
- Back-to-back operation: start=1 during the done cycle is accepted. That edge is the new E0, and the next done follows ROOT_W cycles later. Throughput is one result per ROOT_W+1 cycles.
- busy and done are never high together.
- Critical path per cycle: one ROOT_W+2-bit subtract, plus a compare, plus a mux.

## Test plan
- radicand=0 → after 11 cycles: done=1, root=0, rem=0, exact=1.
- radicand=22'h3FFFFF (4194303) → root=2047, rem=4094, exact=0. Checks the maximum remainder width.
- radicand=22'h100000 (1048576) → root=1024, rem=0, exact=1.
- radicand=22'h200000 (2097152) → root=1448, rem=448, exact=0.
- Back-to-back and ignored start:
  - start with 144, then start pulses with 99 during busy are ignored; result root=12, rem=0.
  - start with 2 asserted in the done cycle → next done exactly 11 cycles later, root=1, rem=1, exact=0.
- Reset mid-operation: rst high for one edge at cycle 5 of RUN, with start held high → busy=0 and all outputs 0 after that edge, no done pulse. The first edge after release accepts start and the run completes normally.
